// File: rtl/sequential_arithmetic_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : sequential_arithmetic_unit_if
// Description : Request/response bundle for sequential_arithmetic_unit.
//               master = requester/consumer side, slave = arithmetic unit.
//               Request : _inValid/inReady, _valA, _valB, _funcCode
//               Response: outValid/_outReady, result, resultHi, overflow,
//                         compareBit, illegalOp
// Revision    : 1.0 - initial release
// ============================================================================
interface sequential_arithmetic_unit_if #(
  parameter int DATA_WIDTH = 16,
  parameter int FUNC_WIDTH = 4
);
  logic                  _inValid;
  logic                  inReady;
  logic [DATA_WIDTH-1:0] _valA;
  logic [DATA_WIDTH-1:0] _valB;
  logic [FUNC_WIDTH-1:0] _funcCode;
  logic                  outValid;
  logic                  _outReady;
  logic [DATA_WIDTH-1:0] result;
  logic [DATA_WIDTH-1:0] resultHi;
  logic                  overflow;
  logic                  compareBit;
  logic                  illegalOp;

  modport master (
    output _inValid, _valA, _valB, _funcCode, _outReady,
    input  inReady, outValid, result, resultHi, overflow, compareBit, illegalOp
  );

  modport slave (
    input  _inValid, _valA, _valB, _funcCode, _outReady,
    output inReady, outValid, result, resultHi, overflow, compareBit, illegalOp
  );
endinterface
`default_nettype wire

// File: rtl/sequential_arithmetic_unit.sv
`default_nettype none
// ============================================================================
// Module      : sequential_arithmetic_unit
// Description : Handshaked ALU. Logic/add/shift/compare ops register their
//               result one cycle after accept; MUL (and DIVU/REMU when
//               SEQ_ALU_DIVIDE_EN is defined) iterate over DATA_WIDTH cycles.
//               The result is held until the consumer accepts it.
// Ports       : _clk, _reset (sync, active-high), bus (slave modport of
//               sequential_arithmetic_unit_if)
// Config      : SEQ_ALU_DIVIDE_EN - include the restoring divider
// Revision    : 1.0 - initial release
// ============================================================================
module sequential_arithmetic_unit #(
  parameter int DATA_WIDTH = 16,
  parameter int FUNC_WIDTH = 4
) (
  input  wire logic                     _clk,
  input  wire logic                     _reset,
  sequential_arithmetic_unit_if.slave   bus
);
  localparam int CW  = $clog2(DATA_WIDTH) + 1;
  localparam int SHW = $clog2(DATA_WIDTH);
  localparam int MSB = DATA_WIDTH - 1;

  localparam logic [FUNC_WIDTH-1:0] c_op_add  = FUNC_WIDTH'(0);
  localparam logic [FUNC_WIDTH-1:0] c_op_sub  = FUNC_WIDTH'(1);
  localparam logic [FUNC_WIDTH-1:0] c_op_and  = FUNC_WIDTH'(2);
  localparam logic [FUNC_WIDTH-1:0] c_op_or   = FUNC_WIDTH'(3);
  localparam logic [FUNC_WIDTH-1:0] c_op_xor  = FUNC_WIDTH'(4);
  localparam logic [FUNC_WIDTH-1:0] c_op_sll  = FUNC_WIDTH'(5);
  localparam logic [FUNC_WIDTH-1:0] c_op_srl  = FUNC_WIDTH'(6);
  localparam logic [FUNC_WIDTH-1:0] c_op_sra  = FUNC_WIDTH'(7);
  localparam logic [FUNC_WIDTH-1:0] c_op_slt  = FUNC_WIDTH'(8);
  localparam logic [FUNC_WIDTH-1:0] c_op_sltu = FUNC_WIDTH'(9);
  localparam logic [FUNC_WIDTH-1:0] c_op_mul  = FUNC_WIDTH'(10);
`ifdef SEQ_ALU_DIVIDE_EN
  localparam logic [FUNC_WIDTH-1:0] c_op_divu = FUNC_WIDTH'(12);
  localparam logic [FUNC_WIDTH-1:0] c_op_remu = FUNC_WIDTH'(13);
`endif

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_iter = 2'd1;
  localparam logic [1:0] c_st_done = 2'd2;

  logic [1:0]            r_state, w_next_state;
  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_a, r_b, r_acc, r_q;
  logic [DATA_WIDTH-1:0] r_result, r_result_hi;
  logic                  r_overflow, r_compare, r_illegal;
`ifdef SEQ_ALU_DIVIDE_EN
  logic [FUNC_WIDTH-1:0] r_func;
`endif

  logic w_accept, w_is_mul, w_is_div, w_div_zero, w_iterative, w_last;

  assign w_accept = bus._inValid && (r_state == c_st_idle);
  assign w_is_mul = (bus._funcCode == c_op_mul);
  assign w_last   = (r_cnt == CW'(1));
`ifdef SEQ_ALU_DIVIDE_EN
  assign w_is_div   = (bus._funcCode == c_op_divu) || (bus._funcCode == c_op_remu);
  assign w_div_zero = w_is_div && (bus._valB == '0);
`else
  assign w_is_div   = 1'b0;
  assign w_div_zero = 1'b0;
`endif
  // Divide by zero has a fixed answer and bypasses the iteration.
  assign w_iterative = w_is_mul || (w_is_div && !w_div_zero);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge _clk) begin
    if (_reset) r_state <= c_st_idle;
    else        r_state <= w_next_state;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle: if (w_accept) w_next_state = w_iterative ? c_st_iter : c_st_done;
      c_st_iter: if (w_last)   w_next_state = c_st_done;
      c_st_done: if (bus._outReady) w_next_state = c_st_idle;
      default:   w_next_state = c_st_idle;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    bus.inReady    = (r_state == c_st_idle);
    bus.outValid   = (r_state == c_st_done);
    bus.result     = r_result;
    bus.resultHi   = r_result_hi;
    bus.overflow   = r_overflow;
    bus.compareBit = r_compare;
    bus.illegalOp  = r_illegal;
  end

  // ---------------- single-cycle datapath ----------------
  logic [DATA_WIDTH-1:0] w_sum, w_diff, w_sc_result;
  logic [SHW-1:0]        w_shamt;
  logic                  w_lt_s, w_lt_u, w_sc_ovf, w_sc_cmp, w_sc_illegal;

  assign w_sum   = bus._valA + bus._valB;
  assign w_diff  = bus._valA - bus._valB;
  assign w_shamt = bus._valB[SHW-1:0];
  assign w_lt_s  = $signed(bus._valA) < $signed(bus._valB);
  assign w_lt_u  = bus._valA < bus._valB;

  always_comb begin
    w_sc_result  = '0;
    w_sc_ovf     = 1'b0;
    w_sc_cmp     = (bus._valA == bus._valB);
    w_sc_illegal = 1'b0;
    case (bus._funcCode)
      c_op_add: begin
        w_sc_result = w_sum;
        w_sc_ovf    = (bus._valA[MSB] == bus._valB[MSB]) && (w_sum[MSB] != bus._valA[MSB]);
      end
      c_op_sub: begin
        // Subtraction adds ~B, so the operand sign compared against is inverted.
        w_sc_result = w_diff;
        w_sc_ovf    = (bus._valA[MSB] != bus._valB[MSB]) && (w_diff[MSB] != bus._valA[MSB]);
      end
      c_op_and:  w_sc_result = bus._valA & bus._valB;
      c_op_or:   w_sc_result = bus._valA | bus._valB;
      c_op_xor:  w_sc_result = bus._valA ^ bus._valB;
      c_op_sll:  w_sc_result = bus._valA << w_shamt;
      c_op_srl:  w_sc_result = bus._valA >> w_shamt;
      c_op_sra:  w_sc_result = $signed(bus._valA) >>> w_shamt;
      c_op_slt: begin
        w_sc_result = {{(DATA_WIDTH-1){1'b0}}, w_lt_s};
        w_sc_cmp    = w_lt_s;
      end
      c_op_sltu: begin
        w_sc_result = {{(DATA_WIDTH-1){1'b0}}, w_lt_u};
        w_sc_cmp    = w_lt_u;
      end
      c_op_mul: w_sc_result = '0;  // produced by the iterative path
`ifdef SEQ_ALU_DIVIDE_EN
      // Only reached as single-cycle ops when the divisor is zero.
      c_op_divu: w_sc_result = '1;
      c_op_remu: w_sc_result = bus._valA;
`endif
      default: w_sc_illegal = 1'b1;
    endcase
  end

  // ---------------- iterative step ----------------
  // MUL: {r_acc, r_q} is the product shifting right; r_q starts as multiplier.
  // DIV: r_acc is the partial remainder, r_q shifts the dividend out and the
  //      quotient in.
  logic [DATA_WIDTH:0]   w_mul_sum;
  logic [DATA_WIDTH-1:0] w_step_acc, w_step_q, w_iter_lo, w_iter_hi;

  assign w_mul_sum = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_a} : '0);

`ifdef SEQ_ALU_DIVIDE_EN
  logic [DATA_WIDTH:0]   w_div_shift;
  logic [DATA_WIDTH+1:0] w_div_diff;
  assign w_div_shift = {r_acc, r_q[MSB]};
  assign w_div_diff  = {1'b0, w_div_shift} - {2'b00, r_b};
`endif

  always_comb begin
    w_step_acc = w_mul_sum[DATA_WIDTH:1];
    w_step_q   = {w_mul_sum[0], r_q[MSB:1]};
    w_iter_lo  = w_step_q;
    w_iter_hi  = w_step_acc;
`ifdef SEQ_ALU_DIVIDE_EN
    if (r_func != c_op_mul) begin
      if (!w_div_diff[DATA_WIDTH+1]) begin
        w_step_acc = w_div_diff[MSB:0];
        w_step_q   = {r_q[MSB-1:0], 1'b1};
      end else begin
        w_step_acc = w_div_shift[MSB:0];
        w_step_q   = {r_q[MSB-1:0], 1'b0};
      end
      w_iter_lo = (r_func == c_op_divu) ? w_step_q : w_step_acc;
      w_iter_hi = '0;
    end
`endif
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge _clk) begin
    if (_reset) begin
      r_cnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_q         <= '0;
      r_result    <= '0;
      r_result_hi <= '0;
      r_overflow  <= 1'b0;
      r_compare   <= 1'b0;
      r_illegal   <= 1'b0;
`ifdef SEQ_ALU_DIVIDE_EN
      r_func      <= '0;
`endif
    end else if (r_state == c_st_idle && w_accept) begin
      r_a <= bus._valA;
      r_b <= bus._valB;
`ifdef SEQ_ALU_DIVIDE_EN
      r_func <= bus._funcCode;
`endif
      if (w_iterative) begin
        r_cnt <= CW'(DATA_WIDTH);
        r_acc <= '0;
        r_q   <= w_is_mul ? bus._valB : bus._valA;
      end else begin
        r_result    <= w_sc_result;
        r_result_hi <= '0;
        r_overflow  <= w_sc_ovf;
        r_compare   <= w_sc_cmp;
        r_illegal   <= w_sc_illegal;
      end
    end else if (r_state == c_st_iter) begin
      r_cnt <= r_cnt - CW'(1);
      r_acc <= w_step_acc;
      r_q   <= w_step_q;
      if (w_last) begin
        r_result    <= w_iter_lo;
        r_result_hi <= w_iter_hi;
        r_overflow  <= 1'b0;
        r_compare   <= (r_a == r_b);
        r_illegal   <= 1'b0;
      end
    end
  end
endmodule
`default_nettype wire
